// File: rtl/seg7_pkg.sv
// seg7_pkg: shared definitions for the seven-segment display path.
// Contents:
//   NUM_DIGITS   number of multiplexed digits on the display bus
//   seg_bits_t   segment bit order, a = bit 6 ... g = bit 0, active-high
//   SEG_0..SEG_F legal hex glyph codes
//   cap_state_t  scan-capture FSM states
//   is_onehot    single-digit-select test
package seg7_pkg;

  localparam int NUM_DIGITS = 8;

  typedef struct packed {
    logic a;
    logic b;
    logic c;
    logic d;
    logic e;
    logic f;
    logic g;
  } seg_bits_t;

  localparam logic [6:0] SEG_0 = 7'h7E;
  localparam logic [6:0] SEG_1 = 7'h30;
  localparam logic [6:0] SEG_2 = 7'h6D;
  localparam logic [6:0] SEG_3 = 7'h79;
  localparam logic [6:0] SEG_4 = 7'h33;
  localparam logic [6:0] SEG_5 = 7'h5B;
  localparam logic [6:0] SEG_6 = 7'h5F;
  localparam logic [6:0] SEG_7 = 7'h70;
  localparam logic [6:0] SEG_8 = 7'h7F;
  localparam logic [6:0] SEG_9 = 7'h7B;
  localparam logic [6:0] SEG_A = 7'h77;
  localparam logic [6:0] SEG_B = 7'h1F;
  localparam logic [6:0] SEG_C = 7'h4E;
  localparam logic [6:0] SEG_D = 7'h3D;
  localparam logic [6:0] SEG_E = 7'h4F;
  localparam logic [6:0] SEG_F = 7'h47;

  typedef enum logic [1:0] {
    ST_WAIT,
    ST_SETTLE,
    ST_HELD
  } cap_state_t;

  function automatic logic is_onehot(input logic [NUM_DIGITS-1:0] v);
    return (v != '0) && ((v & (v - 1'b1)) == '0);
  endfunction

endpackage

// File: rtl/seg7_decode.sv
// seg7_decode: combinational seven-segment pattern to hex nibble decoder.
// Ports:
//   seg    in  7  segment pattern, a = bit 6 ... g = bit 0, active-high
//   nibble out 4  decoded hex value, 0 when the pattern is not a legal glyph
//   legal  out 1  pattern exactly matches one of the 16 hex glyphs
module seg7_decode
  import seg7_pkg::*;
(
  input  logic [6:0] seg,
  output logic [3:0] nibble,
  output logic       legal
);

  seg_bits_t bits;

  always_comb begin
    bits   = seg_bits_t'(seg);
    nibble = '0;
    legal  = 1'b1;
    case (bits)
      SEG_0:   nibble = 4'h0;
      SEG_1:   nibble = 4'h1;
      SEG_2:   nibble = 4'h2;
      SEG_3:   nibble = 4'h3;
      SEG_4:   nibble = 4'h4;
      SEG_5:   nibble = 4'h5;
      SEG_6:   nibble = 4'h6;
      SEG_7:   nibble = 4'h7;
      SEG_8:   nibble = 4'h8;
      SEG_9:   nibble = 4'h9;
      SEG_A:   nibble = 4'hA;
      SEG_B:   nibble = 4'hB;
      SEG_C:   nibble = 4'hC;
      SEG_D:   nibble = 4'hD;
      SEG_E:   nibble = 4'hE;
      SEG_F:   nibble = 4'hF;
      default: legal  = 1'b0;
    endcase
  end

endmodule

// File: rtl/seg7_scan_capture.sv
// seg7_scan_capture: samples a time-multiplexed seven-segment bus, waits for
// each digit to be stable, decodes it and reassembles the displayed word.
// Parameters:
//   SETTLE_CYCLES  consecutive identical samples needed to capture a digit (>=1)
// Ports:
//   clk         in   1  rising-edge clock
//   rst         in   1  synchronous active-high reset
//   dig_sel     in   8  one-hot digit select, bit i -> nibble [4i+3:4i]
//   seg         in   7  segment pattern, a = bit 6 ... g = bit 0
//   value       out 32  last complete reassembled word
//   frame_valid out  1  one-cycle pulse when value updates
//   bad_digit   out  8  per-digit illegal-pattern flags for the frame in value
module seg7_scan_capture
  import seg7_pkg::*;
#(
  parameter int SETTLE_CYCLES = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_DIGITS-1:0]   dig_sel,
  input  logic [6:0]              seg,
  output logic [4*NUM_DIGITS-1:0] value,
  output logic                    frame_valid,
  output logic [NUM_DIGITS-1:0]   bad_digit
);

  localparam int CW = $clog2(SETTLE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(SETTLE_CYCLES);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  logic [NUM_DIGITS-1:0]   r_sel;
  logic [6:0]              r_seg;
  logic [NUM_DIGITS-1:0]   p_sel;
  logic [6:0]              p_seg;

  cap_state_t              state;
  cap_state_t              state_next;
  logic [CW-1:0]           cnt;
  logic [CW-1:0]           cnt_next;
  logic                    capture;

  logic                    sel_onehot;
  logic                    changed;
  logic [3:0]              dec_nib;
  logic                    dec_legal;

  logic [4*NUM_DIGITS-1:0] shadow;
  logic [NUM_DIGITS-1:0]   seen;
  logic [NUM_DIGITS-1:0]   bad_acc;
  logic [4*NUM_DIGITS-1:0] shadow_new;
  logic [NUM_DIGITS-1:0]   seen_new;
  logic [NUM_DIGITS-1:0]   bad_new;
  logic                    frame_done;

  seg7_decode u_decode (
    .seg    (r_seg),
    .nibble (dec_nib),
    .legal  (dec_legal)
  );

  assign sel_onehot = is_onehot(r_sel);
  // p_* is the registered sample from one cycle earlier; stability is judged
  // entirely on the registered copy of the bus.
  assign changed    = {r_sel, r_seg} != {p_sel, p_seg};

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_WAIT;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    capture    = 1'b0;
    case (state)
      ST_WAIT: begin
        if (sel_onehot) begin
          state_next = ST_SETTLE;
          cnt_next   = CNT_ONE;
        end
      end
      ST_SETTLE, ST_HELD: begin
        if (changed) begin
          if (sel_onehot) begin
            state_next = ST_SETTLE;
            cnt_next   = CNT_ONE;
          end else begin
            state_next = ST_WAIT;
            cnt_next   = '0;
          end
        end else if (state == ST_SETTLE && cnt != CNT_MAX) begin
          cnt_next = cnt + 1'b1;
        end
      end
      default: begin
        state_next = ST_WAIT;
        cnt_next   = '0;
      end
    endcase
    // Capture on the same edge the count reaches its target, so that with
    // SETTLE_CYCLES=1 a freshly selected digit is taken immediately.
    if (state_next == ST_SETTLE && cnt_next == CNT_MAX) begin
      capture    = 1'b1;
      state_next = ST_HELD;
    end
  end

  always_comb begin
    shadow_new = shadow;
    bad_new    = bad_acc;
    seen_new   = seen;
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      if (r_sel[i]) begin
        shadow_new[4*i +: 4] = dec_nib;
        bad_new[i]           = ~dec_legal;
        seen_new[i]          = 1'b1;
      end
    end
  end

  assign frame_done = capture && (&seen_new);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sel       <= '0;
      r_seg       <= '0;
      p_sel       <= '0;
      p_seg       <= '0;
      shadow      <= '0;
      seen        <= '0;
      bad_acc     <= '0;
      value       <= '0;
      bad_digit   <= '0;
      frame_valid <= 1'b0;
    end else begin
      r_sel       <= dig_sel;
      r_seg       <= seg;
      p_sel       <= r_sel;
      p_seg       <= r_seg;
      frame_valid <= 1'b0;
      if (capture) begin
        shadow <= shadow_new;
        if (frame_done) begin
          value       <= shadow_new;
          bad_digit   <= bad_new;
          frame_valid <= 1'b1;
          seen        <= '0;
          bad_acc     <= '0;
        end else begin
          seen    <= seen_new;
          bad_acc <= bad_new;
        end
      end
    end
  end

endmodule
